// File: rtl/sap1_prog_loader.sv
// SAP-1 program loader: accepts LEN/program/checksum bytes into the 16x8 RAM,
// zero-fills the unused words, then lets the CPU run (free or single-step) until HLT.
module sap1_prog_loader #(
   parameter int ADDR_W = 4,
   parameter int DATA_W = 8
) (
   input  logic              clk,
   input  logic              clr,
   input  logic              start,
   input  logic              s_valid,
   input  logic [DATA_W-1:0] s_data,
   output logic              s_ready,
   input  logic              step_mode,
   input  logic              step,
   input  logic              cpu_halt_n,
   output logic              ram_we,
   output logic [ADDR_W-1:0] ram_addr,
   output logic [DATA_W-1:0] ram_wdata,
   output logic              cpu_clr,
   output logic              cpu_clk_en,
   output logic              busy,
   output logic              done,
   output logic              err,
   output logic [ADDR_W:0]   loaded_cnt
);

   localparam int DEPTH = 1 << ADDR_W;

   typedef enum logic [2:0] {
      S_IDLE,
      S_LEN,
      S_DATA,
      S_CSUM,
      S_FILL,
      S_RUN,
      S_HALTED,
      S_ERROR
   } state_t;

   state_t            state_q, state_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [ADDR_W:0]   len_q, len_d;
   logic [ADDR_W:0]   cnt_q, cnt_d;
   logic [DATA_W-1:0] sum_q, sum_d;
   logic              step_q;
   logic              clk_en_q, clk_en_d;

   logic              xfer;
   logic              step_edge;
   logic              run_en;
   logic              len_ok;
   logic [DATA_W-1:0] sum_next;
   logic [ADDR_W:0]   cnt_inc;

   assign xfer      = s_valid & s_ready;
   assign step_edge = step & ~step_q;
   // Enable the CPU clock for the coming cycle: always in free run, once per step edge otherwise.
   assign run_en    = step_mode ? step_edge : 1'b1;
   assign len_ok    = (s_data != '0) && (s_data <= DATA_W'(DEPTH));
   assign sum_next  = sum_q + s_data;
   assign cnt_inc   = cnt_q + 1'b1;

   // NOTE: every variable gets a default at the top of the block so no path infers a latch.
   always_comb begin
      state_d  = state_q;
      addr_d   = addr_q;
      len_d    = len_q;
      cnt_d    = cnt_q;
      sum_d    = sum_q;
      clk_en_d = 1'b0;

      unique case (state_q)
         S_IDLE, S_HALTED, S_ERROR: begin
            if (start) begin
               state_d = S_LEN;
               cnt_d   = '0;
            end
         end
         S_LEN: begin
            if (xfer) begin
               if (len_ok) begin
                  state_d = S_DATA;
                  len_d   = s_data[ADDR_W:0];
                  sum_d   = s_data;
                  addr_d  = '0;
                  cnt_d   = '0;
               end else begin
                  state_d = S_ERROR;
               end
            end
         end
         S_DATA: begin
            if (xfer) begin
               addr_d = addr_q + 1'b1;
               cnt_d  = cnt_inc;
               sum_d  = sum_next;
               if (cnt_inc == len_q) state_d = S_CSUM;
            end
         end
         S_CSUM: begin
            if (xfer) begin
               if (sum_next != '0) begin
                  state_d = S_ERROR;
               end else if (len_q == (ADDR_W+1)'(DEPTH)) begin
                  state_d  = S_RUN;
                  clk_en_d = run_en;
               end else begin
                  state_d = S_FILL;
               end
            end
         end
         S_FILL: begin
            addr_d = addr_q + 1'b1;
            // The last word written is the top address; the wrap back to zero ends the fill.
            if (addr_q == '1) begin
               state_d  = S_RUN;
               clk_en_d = run_en;
            end
         end
         S_RUN: begin
            if (!cpu_halt_n) state_d = S_HALTED;
            else             clk_en_d = run_en;
         end
         default: state_d = S_IDLE;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so all registers update together.
   always_ff @(posedge clk or posedge clr) begin
      if (clr) begin
         state_q  <= S_IDLE;
         addr_q   <= '0;
         len_q    <= '0;
         cnt_q    <= '0;
         sum_q    <= '0;
         step_q   <= 1'b0;
         clk_en_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         addr_q   <= addr_d;
         len_q    <= len_d;
         cnt_q    <= cnt_d;
         sum_q    <= sum_d;
         step_q   <= step;
         clk_en_q <= clk_en_d;
      end
   end

   // Write port decodes from the state register so an asynchronous clear drops ram_we at once.
   always_comb begin
      s_ready   = (state_q == S_LEN) || (state_q == S_DATA) || (state_q == S_CSUM);
      ram_we    = ((state_q == S_DATA) && s_valid) || (state_q == S_FILL);
      ram_addr  = ((state_q == S_DATA) || (state_q == S_FILL)) ? addr_q : '0;
      ram_wdata = (state_q == S_DATA) ? s_data : '0;
      cpu_clr   = !((state_q == S_RUN) || (state_q == S_HALTED));
      busy      = (state_q == S_LEN) || (state_q == S_DATA) ||
                  (state_q == S_CSUM) || (state_q == S_FILL);
      done      = (state_q == S_HALTED);
      err       = (state_q == S_ERROR);
   end

   assign cpu_clk_en = clk_en_q;
   assign loaded_cnt = cnt_q;

endmodule
